mem_bus_arbiter: RTL

//  Shares the single SoC memory bus between the instruction-fetch port and the data (mem-stage) port.

---
 rtl/mem_bus_arbiter.sv | 75 +++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between fetch and data ports with data priority, a fetch-progress burst limit and a watchdog
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_BURST_MAX = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [ADDR_WIDTH-1:0] instr_address_in,
  input  logic                  instr_read_in,
  output logic [31:0]           instr_read_value_out,
  output logic                  instr_ready_out,
  input  logic [ADDR_WIDTH-1:0] data_address_in,
  input  logic                  data_read_in,
  input  logic                  data_write_in,
  input  logic [31:0]           data_write_value_in,
  input  logic [3:0]            data_write_mask_in,
  output logic [31:0]           data_read_value_out,
  output logic                  data_ready_out,
  output logic [ADDR_WIDTH-1:0] bus_address_out,
  output logic                  bus_read_out,
  output logic                  bus_write_out,
  output logic [31:0]           bus_write_value_out,
  output logic [3:0]            bus_write_mask_out,
  input  logic [31:0]           bus_read_value_in,
  input  logic                  bus_ready_in,
  output logic                  bus_error_out
);
  localparam int BW = $clog2(DATA_BURST_MAX + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [BW-1:0] burst_max = BW'(DATA_BURST_MAX);
  localparam logic [WW-1:0] wd_last = WW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, GRANT_INSTR, GRANT_DATA} state_t;
  state_t state, state_nx;
  logic [BW-1:0] burst_cnt;
  logic [WW-1:0] wd_cnt;
  logic data_req, is_i, is_d, strobe, done, timeout, enter_i, enter_d;
  always_comb begin
    data_req = data_read_in | data_write_in;
    is_i = state == GRANT_INSTR;
    is_d = state == GRANT_DATA;
    strobe = is_i ? instr_read_in : is_d & data_req;
    done = strobe & bus_ready_in;
    timeout = (TIMEOUT_CYCLES != 0) && strobe && !bus_ready_in && wd_cnt == wd_last;
    state_nx = state;
    if (state == IDLE)
      state_nx = data_req && (!instr_read_in || burst_cnt != burst_max) ? GRANT_DATA :
                 instr_read_in ? GRANT_INSTR : IDLE;
    else if (!strobe || done || timeout)
      state_nx = IDLE;
    enter_i = state == IDLE && state_nx == GRANT_INSTR;
    enter_d = state == IDLE && state_nx == GRANT_DATA;
    bus_address_out = is_i ? instr_address_in : is_d ? data_address_in : '0;
    bus_read_out = is_i ? instr_read_in : is_d & data_read_in & ~data_write_in;
    bus_write_out = is_d & data_write_in;
    bus_write_value_out = is_d ? data_write_value_in : '0;
    bus_write_mask_out = is_d ? data_write_mask_in : '0;
    instr_ready_out = is_i & (done | timeout);
    data_ready_out = is_d & (done | timeout);
    instr_read_value_out = is_i & done ? bus_read_value_in : '0;
    data_read_value_out = is_d & done ? bus_read_value_in : '0;
    bus_error_out = timeout;
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state <= IDLE;
      burst_cnt <= '0;
      wd_cnt <= '0;
    end else begin
      state <= state_nx;
      wd_cnt <= state == IDLE ? '0 : wd_cnt + 1'b1;
      burst_cnt <= !instr_read_in || enter_i ? '0 :
                   enter_d && burst_cnt != burst_max ? burst_cnt + 1'b1 : burst_cnt;
    end
endmodule
